// File: rtl/wb_pkg.sv
// Shared definitions for the write-back / register-file slice.
// Optional feature macro: WB_R0_ZERO_EN (register 0 hard-wired to zero).
package wb_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int PEND_W   = 2;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // MEM/WB register outputs as seen by the write-back stage
  typedef struct packed {
    logic              memtoreg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] write_reg;
    logic              regwrite;
  } wb_bus_t;

endpackage

// File: rtl/wb_regfile_scoreboard.sv
// Per-register pending-write scoreboard: counts in-flight writers, blocks
// issues whose sources are still pending, and flags write-back underflow.
// Optional feature macro: WB_R0_ZERO_EN (register 0 never reserves).
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] wb_write_reg,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              rd_use_a,
  input  logic              rd_use_b,
  input  logic              issue_valid,
  input  logic              issue_regwrite,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              issue_stall,
  output logic              sb_error
);

  logic [PEND_W-1:0]   pend_q [NUM_REGS];
  logic [PEND_W-1:0]   pend_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_hit;
  logic [NUM_REGS-1:0] dec_hit;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] underflow;
  logic                sat;
  logic                do_inc;
  logic                sb_error_q;
  logic                sb_error_d;

  // Stall decision: a source is busy if it stays pending after this cycle's retire
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      dec_hit[r] = wb_regwrite && (wb_write_reg == ADDR_W'(r));
      // A retiring write to a register with nothing pending leaves it free
      busy[r]    = dec_hit[r] ? (pend_q[r] > PEND_W'(1)) : (pend_q[r] != '0);
    end
    sat         = issue_regwrite && (pend_q[issue_dst] == '1);
    issue_stall = issue_valid &&
                  ((rd_use_a && busy[rd_addr_a]) ||
                   (rd_use_b && busy[rd_addr_b]) ||
                   sat);
    do_inc      = issue_valid && issue_regwrite && !issue_stall;
`ifdef WB_R0_ZERO_EN
    if (issue_dst == '0) do_inc = 1'b0;
`endif
  end

  // Next counter values and underflow detection
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_hit[r]   = do_inc && (issue_dst == ADDR_W'(r));
      pend_d[r]    = pend_q[r];
      underflow[r] = 1'b0;
      if (inc_hit[r] && !dec_hit[r]) begin
        pend_d[r] = pend_q[r] + PEND_W'(1);
      end else if (dec_hit[r] && !inc_hit[r]) begin
        if (pend_q[r] == '0) underflow[r] = 1'b1;
        else                 pend_d[r]    = pend_q[r] - PEND_W'(1);
      end
    end
`ifdef WB_R0_ZERO_EN
    // r0 never reserves, so its write-backs are not underflows
    underflow[0] = 1'b0;
`endif
    sb_error_d = sb_error_q || (|underflow);
  end

  // Counter and sticky error state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
      sb_error_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
      sb_error_q <= sb_error_d;
    end
  end

  assign sb_error = sb_error_q;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it to an
// 8 x 16 register file with write-through read bypass, and hosts the
// pending-write scoreboard used by decode for stalls.
// Optional feature macro: WB_R0_ZERO_EN (register 0 reads zero, ignores writes).
module wb_regfile
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_memtoreg,
  input  logic [DATA_W-1:0] wb_read_data,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [ADDR_W-1:0] wb_write_reg,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              rd_use_a,
  input  logic              rd_use_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              issue_valid,
  input  logic              issue_regwrite,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              issue_stall,
  output logic [15:0]       retire_count,
  output logic              sb_error
);

  wb_bus_t           wb;
  logic [DATA_W-1:0] wb_val;
  logic              wr_en;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [15:0]       retire_q;
  logic [15:0]       retire_d;

  assign wb = '{memtoreg:   wb_memtoreg,
                read_data:  wb_read_data,
                alu_result: wb_alu_result,
                write_reg:  wb_write_reg,
                regwrite:   wb_regwrite};

  // Write-back value select and effective register-write enable
  always_comb begin
    wb_val   = wb.memtoreg ? wb.read_data : wb.alu_result;
    wr_en    = wb.regwrite;
`ifdef WB_R0_ZERO_EN
    if (wb.write_reg == '0) wr_en = 1'b0;
`endif
    retire_d = wb.regwrite ? retire_q + 16'd1 : retire_q;
  end

  // Register array and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      retire_q <= '0;
    end else begin
      if (wr_en) regs_q[wb.write_reg] <= wb_val;
      retire_q <= retire_d;
    end
  end

  // Read ports with write-through bypass (wr_en already excludes r0 when hard-wired)
  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
    if (wr_en && (wb.write_reg == rd_addr_a)) rd_data_a = wb_val;
    if (wr_en && (wb.write_reg == rd_addr_b)) rd_data_b = wb_val;
`ifdef WB_R0_ZERO_EN
    if (rd_addr_a == '0) rd_data_a = '0;
    if (rd_addr_b == '0) rd_data_b = '0;
`endif
  end

  assign retire_count = retire_q;

  wb_scoreboard u_sb (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_regwrite    (wb.regwrite),
    .wb_write_reg   (wb.write_reg),
    .rd_addr_a      (rd_addr_a),
    .rd_addr_b      (rd_addr_b),
    .rd_use_a       (rd_use_a),
    .rd_use_b       (rd_use_b),
    .issue_valid    (issue_valid),
    .issue_regwrite (issue_regwrite),
    .issue_dst      (issue_dst),
    .issue_stall    (issue_stall),
    .sb_error       (sb_error)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: a behavioural model produces expected
// values that are queued when stimulus is applied and compared on output.
module tb_wb_regfile;
  import wb_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wb_memtoreg;
  logic [DATA_W-1:0] wb_read_data;
  logic [DATA_W-1:0] wb_alu_result;
  logic [ADDR_W-1:0] wb_write_reg;
  logic              wb_regwrite;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              rd_use_a;
  logic              rd_use_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              issue_valid;
  logic              issue_regwrite;
  logic [ADDR_W-1:0] issue_dst;
  logic              issue_stall;
  logic [15:0]       retire_count;
  logic              sb_error;

  wb_regfile dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_memtoreg    (wb_memtoreg),
    .wb_read_data   (wb_read_data),
    .wb_alu_result  (wb_alu_result),
    .wb_write_reg   (wb_write_reg),
    .wb_regwrite    (wb_regwrite),
    .rd_addr_a      (rd_addr_a),
    .rd_addr_b      (rd_addr_b),
    .rd_use_a       (rd_use_a),
    .rd_use_b       (rd_use_b),
    .rd_data_a      (rd_data_a),
    .rd_data_b      (rd_data_b),
    .issue_valid    (issue_valid),
    .issue_regwrite (issue_regwrite),
    .issue_dst      (issue_dst),
    .issue_stall    (issue_stall),
    .retire_count   (retire_count),
    .sb_error       (sb_error)
  );

  always #5 clk = ~clk;

  localparam int SRC_RDA = 0, SRC_RDB = 1, SRC_STALL = 2, SRC_RET = 3, SRC_ERR = 4;

  typedef struct {
    string       tag;
    int          src;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference model state
  logic [15:0] m_regs [8];
  int          m_pend [8];
  logic [15:0] m_ret;
  bit          m_err;
  bit          m_st;

`ifdef WB_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int src);
    case (src)
      SRC_RDA:   return {16'h0, rd_data_a};
      SRC_RDB:   return {16'h0, rd_data_b};
      SRC_STALL: return {31'h0, issue_stall};
      SRC_RET:   return {16'h0, retire_count};
      default:   return {31'h0, sb_error};
    endcase
  endfunction

  function automatic void push_exp(input string tag, input int src, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.src = src; e.exp = exp;
    sbq.push_back(e);
  endfunction

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, observe(e.src), e.exp);
    end
  endtask

  function automatic logic [15:0] m_wbval();
    return wb_memtoreg ? wb_read_data : wb_alu_result;
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] a);
    if (R0Z && a == 3'd0) return 16'h0;
    if (wb_regwrite && wb_write_reg == a) return m_wbval();
    return m_regs[a];
  endfunction

  function automatic bit m_busy(input logic [2:0] a);
    int p;
    p = m_pend[a];
    if (wb_regwrite && wb_write_reg == a) p = p - 1;
    return p > 0;
  endfunction

  function automatic bit m_stall();
    if (!issue_valid) return 1'b0;
    return (rd_use_a && m_busy(rd_addr_a)) || (rd_use_b && m_busy(rd_addr_b)) ||
           (issue_regwrite && m_pend[issue_dst] == 3);
  endfunction

  function automatic void m_reset();
    for (int r = 0; r < 8; r++) begin
      m_regs[r] = 16'h0;
      m_pend[r] = 0;
    end
    m_ret = 16'h0;
    m_err = 1'b0;
  endfunction

  function automatic void m_clock(input bit st);
    bit inc;
    inc = issue_valid && issue_regwrite && !st && !(R0Z && issue_dst == 3'd0);
    if (wb_regwrite) begin
      m_ret = m_ret + 16'd1;
      if (!(R0Z && wb_write_reg == 3'd0)) m_regs[wb_write_reg] = m_wbval();
    end
    if (inc && wb_regwrite && issue_dst == wb_write_reg) begin
      // reservation and retirement cancel out
    end else begin
      if (inc) m_pend[issue_dst] = m_pend[issue_dst] + 1;
      if (wb_regwrite) begin
        if (m_pend[wb_write_reg] == 0) begin
          if (!(R0Z && wb_write_reg == 3'd0)) m_err = 1'b1;
        end else begin
          m_pend[wb_write_reg] = m_pend[wb_write_reg] - 1;
        end
      end
    end
  endfunction

  task automatic idle();
    wb_memtoreg = 0; wb_read_data = '0; wb_alu_result = '0; wb_write_reg = '0;
    wb_regwrite = 0; rd_addr_a = '0; rd_addr_b = '0; rd_use_a = 0; rd_use_b = 0;
    issue_valid = 0; issue_regwrite = 0; issue_dst = '0;
  endtask

  // Called just after a negedge with inputs already driven
  task automatic step();
    #1;
    m_st = m_stall();
    push_exp("rd_a", SRC_RDA, {16'h0, m_read(rd_addr_a)});
    push_exp("rd_b", SRC_RDB, {16'h0, m_read(rd_addr_b)});
    push_exp("stall", SRC_STALL, {31'h0, m_st});
    drain();
    @(posedge clk);
    m_clock(m_st);
    #1;
    push_exp("retire", SRC_RET, {16'h0, m_ret});
    push_exp("sb_err", SRC_ERR, {31'h0, m_err});
    drain();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    m_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state: every register reads zero
    for (int r = 0; r < 8; r++) begin
      idle();
      rd_addr_a = 3'(r); rd_addr_b = 3'(7 - r);
      issue_valid = 1; rd_use_a = 1; rd_use_b = 1;
      push_exp("rst_rd_a", SRC_RDA, 32'h0);
      push_exp("rst_stall", SRC_STALL, 32'h0);
      step();
    end

    // RAW hazard on r3, resolved by a same-cycle bypassed write-back
    idle(); issue_valid = 1; issue_regwrite = 1; issue_dst = 3'd3;
    step();
    idle(); issue_valid = 1; rd_addr_a = 3'd3; rd_use_a = 1;
    push_exp("raw_stall", SRC_STALL, 32'h1);
    step();
    wb_regwrite = 1; wb_memtoreg = 1; wb_read_data = 16'hBEEF;
    wb_alu_result = 16'h5555; wb_write_reg = 3'd3;
    push_exp("bypass_stall", SRC_STALL, 32'h0);
    push_exp("bypass_a", SRC_RDA, 32'hBEEF);
    step();
    idle(); rd_addr_a = 3'd3;
    push_exp("r3_commit", SRC_RDA, 32'hBEEF);
    step();

    // Underflow: write-back to r5 with no reservation
    idle(); wb_regwrite = 1; wb_memtoreg = 0; wb_alu_result = 16'h1234;
    wb_read_data = 16'hDEAD; wb_write_reg = 3'd5;
    step();
    idle(); rd_addr_b = 3'd5;
    push_exp("r5_alu", SRC_RDB, 32'h1234);
    push_exp("err_sticky_pre", SRC_ERR, 32'h1);
    step();
    idle();
    step();

    // Saturation guard on r2
    for (int i = 0; i < 3; i++) begin
      idle(); issue_valid = 1; issue_regwrite = 1; issue_dst = 3'd2;
      step();
    end
    idle(); issue_valid = 1; issue_regwrite = 1; issue_dst = 3'd2;
    push_exp("sat_stall", SRC_STALL, 32'h1);
    step();
    idle(); wb_regwrite = 1; wb_alu_result = 16'h2222; wb_write_reg = 3'd2;
    step();
    idle(); issue_valid = 1; issue_regwrite = 1; issue_dst = 3'd2;
    push_exp("sat_clear", SRC_STALL, 32'h0);
    step();

    // Asynchronous reset pulse between edges with pend[4] = 2
    for (int i = 0; i < 2; i++) begin
      idle(); issue_valid = 1; issue_regwrite = 1; issue_dst = 3'd4;
      step();
    end
    idle(); rd_addr_a = 3'd3; rd_addr_b = 3'd5;
    #1 rst_n = 1'b0;
    #1;
    push_exp("arst_ret", SRC_RET, 32'h0);
    push_exp("arst_err", SRC_ERR, 32'h0);
    push_exp("arst_r3", SRC_RDA, 32'h0);
    push_exp("arst_r5", SRC_RDB, 32'h0);
    drain();
    #2 rst_n = 1'b1;
    m_reset();
    @(negedge clk);
    idle(); issue_valid = 1; rd_addr_a = 3'd4; rd_use_a = 1;
    push_exp("post_rst_stall", SRC_STALL, 32'h0);
    step();

    // Register 0 behaviour
    idle(); wb_regwrite = 1; wb_alu_result = 16'hFFFF; wb_write_reg = 3'd0; rd_addr_a = 3'd0;
    push_exp("r0_bypass", SRC_RDA, R0Z ? 32'h0 : 32'hFFFF);
    step();
    idle(); rd_addr_a = 3'd0;
    push_exp("r0_read", SRC_RDA, R0Z ? 32'h0 : 32'hFFFF);
    step();

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      idle();
      wb_regwrite    = ($urandom_range(0, 2) == 0);
      wb_memtoreg    = 1'($urandom);
      wb_read_data   = 16'($urandom);
      wb_alu_result  = 16'($urandom);
      wb_write_reg   = 3'($urandom);
      rd_addr_a      = 3'($urandom);
      rd_addr_b      = 3'($urandom);
      rd_use_a       = 1'($urandom);
      rd_use_b       = 1'($urandom);
      issue_valid    = 1'($urandom);
      issue_regwrite = 1'($urandom);
      issue_dst      = 3'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
